// File: rtl/decompressor.sv
// Line decompressor: pulls packed bytes through a 64-byte alignment buffer and
// re-expands each tag's significant bytes into a full 256-bit cache line.
module decompressor (
    input  logic         clk,
    input  logic         reset,
    input  logic         inValid,
    output logic         inReady,
    input  logic [255:0] inData,
    input  logic         tagValid,
    output logic         tagReady,
    input  logic [15:0]  tagIn,
    input  logic         tagLast,
    output logic         outValid,
    input  logic         outReady,
    output logic [255:0] dataOut,
    output logic [15:0]  tagOut,
    output logic         lastOut
);

    logic [511:0] buf_q, buf_d;
    logic [6:0]   count_q, count_d;
    logic [4:0]   frame_off_q, frame_off_d;
    logic         out_valid_q, out_valid_d;
    logic [255:0] data_q, data_d;
    logic [15:0]  tag_q, tag_d;
    logic         last_q, last_d;

    logic [7:0]   front [32];
    logic [255:0] line;
    logic [5:0]   len;
    logic [4:0]   sum5;
    logic [4:0]   pad;
    logic [6:0]   need;
    logic [6:0]   consumed;
    logic [6:0]   remain;
    logic         fire;
    logic         accept;
    logic [1:0]   code;
    logic [2:0]   nb;

    always_comb begin
        for (int unsigned i = 0; i < 32; i++) begin
            front[i] = buf_q[511 - 8*i -: 8];
        end
    end

    // Running byte offset walks the front of the buffer word by word, MSB word first.
    always_comb begin
        len  = '0;
        line = '0;
        code = '0;
        nb   = '0;
        for (int unsigned w = 0; w < 8; w++) begin
            code = tagIn[15 - 2*w -: 2];
            case (code)
                2'd0:    nb = 3'd0;
                2'd1:    nb = 3'd1;
                2'd2:    nb = 3'd2;
                default: nb = 3'd4;
            endcase
            for (int unsigned b = 0; b < 4; b++) begin
                if (b < 32'(nb)) begin
                    line[255 - 32*w - 8*b -: 8] = front[5'(32'(len) + b)];
                end
            end
            len = len + 6'(nb);
        end
    end

    always_comb begin
        sum5     = frame_off_q + len[4:0];
        pad      = tagLast ? (5'd0 - sum5) : 5'd0;
        need     = {1'b0, len} + {2'b00, pad};
        inReady  = (count_q <= 7'd32);
        accept   = inValid && inReady;
        fire     = tagValid && (count_q >= need) && (!out_valid_q || outReady);
        tagReady = fire;
        consumed = fire ? need : 7'd0;
        remain   = count_q - consumed;
    end

    always_comb begin
        buf_d = buf_q << {consumed, 3'b000};
        if (accept) begin
            // Bytes past count are always zero, so the new beat can simply be OR'd in.
            buf_d = buf_d | ({inData, 256'b0} >> {remain, 3'b000});
        end
        count_d     = remain + (accept ? 7'd32 : 7'd0);
        frame_off_d = fire ? (tagLast ? 5'd0 : sum5) : frame_off_q;
        out_valid_d = fire || (out_valid_q && !outReady);
        data_d      = fire ? line    : data_q;
        tag_d       = fire ? tagIn   : tag_q;
        last_d      = fire ? tagLast : last_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q       <= '0;
            count_q     <= '0;
            frame_off_q <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            tag_q       <= '0;
            last_q      <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            count_q     <= count_d;
            frame_off_q <= frame_off_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            tag_q       <= tag_d;
            last_q      <= last_d;
        end
    end

    assign outValid = out_valid_q;
    assign dataOut  = data_q;
    assign tagOut   = tag_q;
    assign lastOut  = last_q;

endmodule

// File: tb/tb_decompressor.sv
// Bench for decompressor: lines are packed by a byte-level compressor model and
// the reconstructed output stream must reproduce the original lines in order.
module tb_decompressor;

    logic         clk;
    logic         reset;
    logic         inValid;
    logic         inReady;
    logic [255:0] inData;
    logic         tagValid;
    logic         tagReady;
    logic [15:0]  tagIn;
    logic         tagLast;
    logic         outValid;
    logic         outReady;
    logic [255:0] dataOut;
    logic [15:0]  tagOut;
    logic         lastOut;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    decompressor dut (
        .clk      (clk),
        .reset    (reset),
        .inValid  (inValid),
        .inReady  (inReady),
        .inData   (inData),
        .tagValid (tagValid),
        .tagReady (tagReady),
        .tagIn    (tagIn),
        .tagLast  (tagLast),
        .outValid (outValid),
        .outReady (outReady),
        .dataOut  (dataOut),
        .tagOut   (tagOut),
        .lastOut  (lastOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // stream model state
    logic [7:0]   byte_q[$];
    logic [255:0] beats_q[$];
    logic [15:0]  tags_q[$];
    bit           tlast_q[$];
    logic [255:0] exp_q[$];
    int           frame_len;

    // observations
    logic [255:0] obs_data_q[$];
    logic [15:0]  obs_tag_q[$];
    bit           obs_last_q[$];
    int           obs_cyc_q[$];
    bit           timeout, count_over, stall_changed, stall_tr, stall_ir_low;

    function automatic logic [15:0] tag_of(input logic [255:0] l);
        logic [15:0] t;
        logic [31:0] wd;
        t = '0;
        for (int w = 0; w < 8; w++) begin
            wd = l[255 - 32*w -: 32];
            if (wd == 0)                t[15 - 2*w -: 2] = 2'd0;
            else if (wd[23:0] == 24'd0) t[15 - 2*w -: 2] = 2'd1;
            else if (wd[15:0] == 16'd0) t[15 - 2*w -: 2] = 2'd2;
            else                        t[15 - 2*w -: 2] = 2'd3;
        end
        return t;
    endfunction

    function automatic logic [255:0] gen_line(input logic [15:0] t);
        logic [255:0] l;
        logic [31:0]  wd;
        l = '0;
        for (int w = 0; w < 8; w++) begin
            case (t[15 - 2*w -: 2])
                2'd0:    wd = 32'd0;
                2'd1:    wd = {8'($urandom_range(255, 1)), 24'd0};
                2'd2:    wd = {8'($urandom), 8'($urandom_range(255, 1)), 16'd0};
                default: wd = {16'($urandom), 16'($urandom_range(65535, 1))};
            endcase
            l[255 - 32*w -: 32] = wd;
        end
        return l;
    endfunction

    task automatic clear_model();
        byte_q.delete(); beats_q.delete(); tags_q.delete(); tlast_q.delete(); exp_q.delete();
        obs_data_q.delete(); obs_tag_q.delete(); obs_last_q.delete(); obs_cyc_q.delete();
        frame_len = 0;
        timeout = 0; count_over = 0; stall_changed = 0; stall_tr = 0; stall_ir_low = 0;
    endtask

    task automatic add_line(input logic [255:0] l, input logic [15:0] t, input bit last);
        int nb;
        for (int w = 0; w < 8; w++) begin
            nb = int'(t[15 - 2*w -: 2]);
            if (nb == 3) nb = 4;
            for (int b = 0; b < nb; b++) byte_q.push_back(l[255 - 32*w - 8*b -: 8]);
            frame_len += nb;
        end
        if (last) begin
            while (frame_len % 32 != 0) begin
                byte_q.push_back(8'($urandom));
                frame_len++;
            end
            frame_len = 0;
        end
        tags_q.push_back(t);
        tlast_q.push_back(last);
        exp_q.push_back(l);
    endtask

    task automatic finish_stream();
        logic [255:0] beat;
        while (byte_q.size() % 32 != 0) byte_q.push_back(8'h00);
        for (int i = 0; i < byte_q.size(); i += 32) begin
            beat = '0;
            for (int j = 0; j < 32; j++) beat = {beat[247:0], byte_q[i + j]};
            beats_q.push_back(beat);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; inValid = 0; inData = '0; tagValid = 0; tagIn = '0; tagLast = 0; outReady = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_traffic(input int in_pct, input int tag_pct, input int out_pct,
                               input int stall_len, input int max_cyc);
        fork
            begin : beat_proc
                int bi = 0;
                bit acc = 0;
                for (int c = 0; c < max_cyc; c++) begin
                    @(posedge clk); #1;
                    if (acc) bi++;
                    if (bi >= beats_q.size()) begin inValid = 0; break; end
                    inValid = ($urandom_range(99) < in_pct);
                    inData  = beats_q[bi];
                    @(negedge clk);
                    acc = inValid && inReady;
                end
                if (bi < beats_q.size()) timeout = 1;
                inValid = 0;
            end
            begin : tag_proc
                int ti = 0;
                bit acc = 0;
                for (int c = 0; c < max_cyc; c++) begin
                    @(posedge clk); #1;
                    if (acc) ti++;
                    if (ti >= tags_q.size()) begin tagValid = 0; break; end
                    tagValid = ($urandom_range(99) < tag_pct);
                    tagIn    = tags_q[ti];
                    tagLast  = tlast_q[ti];
                    @(negedge clk);
                    acc = tagValid && tagReady;
                end
                if (ti < tags_q.size()) timeout = 1;
                tagValid = 0;
            end
            begin : out_proc
                bit started = 0;
                bit in_stall = 0;
                int rem = 0;
                logic [255:0] snap_d;
                logic [15:0]  snap_t;
                for (int c = 0; c < max_cyc; c++) begin
                    @(posedge clk); #1;
                    if (!started && stall_len > 0 && outValid) begin
                        started = 1; rem = stall_len; snap_d = dataOut; snap_t = tagOut;
                    end
                    if (rem > 0) begin
                        outReady = 0; rem--; in_stall = 1;
                    end else begin
                        outReady = ($urandom_range(99) < out_pct); in_stall = 0;
                    end
                    @(negedge clk);
                    if (dut.count_q > 7'd64) count_over = 1;
                    if (in_stall) begin
                        if (dataOut !== snap_d || tagOut !== snap_t) stall_changed = 1;
                        if (tagReady) stall_tr = 1;
                        if (!inReady) stall_ir_low = 1;
                    end
                    if (outValid && outReady) begin
                        obs_data_q.push_back(dataOut);
                        obs_tag_q.push_back(tagOut);
                        obs_last_q.push_back(lastOut);
                        obs_cyc_q.push_back(cyc);
                    end
                    if (obs_data_q.size() >= exp_q.size()) break;
                end
                if (obs_data_q.size() < exp_q.size()) timeout = 1;
                @(posedge clk); #1;
                outReady = 0;
            end
        join
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge clk); #1;
        tagValid = 1; tagIn = 16'hFFFF;
        @(negedge clk);
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL reset_outValid got=%b want=0", outValid); end
        total++; if (dataOut !== '0) begin bad++; $display("FAIL reset_dataOut got=%h want=0", dataOut); end
        total++; if (inReady !== 1'b1) begin bad++; $display("FAIL reset_inReady got=%b want=1", inReady); end
        total++; if (tagReady !== 1'b0) begin bad++; $display("FAIL reset_tagReady got=%b want=0", tagReady); end
        @(posedge clk); #1;
        tagValid = 0;
        inValid = 1; inData = {8{32'($urandom)}};
        @(posedge clk); @(posedge clk); #1;
        inValid = 0; outReady = 0;
        tagValid = 1; tagIn = 16'hFFF0; tagLast = 0;
        @(posedge clk); #1;
        tagValid = 0;
        @(negedge clk);
        total++; if (dut.count_q !== 7'd40) begin bad++; $display("FAIL pre_reset_count got=%0d want=40", dut.count_q); end
        total++; if (outValid !== 1'b1) begin bad++; $display("FAIL pre_reset_outValid got=%b want=1", outValid); end
        total++; if (inReady !== 1'b0) begin bad++; $display("FAIL pre_reset_inReady got=%b want=0", inReady); end
        #1 reset = 1'b1;
        #1;
        total++; if (dut.count_q !== 7'd0) begin bad++; $display("FAIL midreset_count got=%0d want=0", dut.count_q); end
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL midreset_outValid got=%b want=0", outValid); end
        total++; if (inReady !== 1'b1) begin bad++; $display("FAIL midreset_inReady got=%b want=1", inReady); end
        total++; if (dataOut !== '0) begin bad++; $display("FAIL midreset_dataOut got=%h want=0", dataOut); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_six_lines();
        logic [15:0] t6 [6];
        logic [255:0] first;
        t6 = '{16'h46DB, 16'hA964, 16'h0625, 16'h800B, 16'h0000, 16'hFFFF};
        first = 256'h12000000_00000000_34000000_56780000_9ABCDEF1_23000000_45670000_89ABCDEF;
        do_reset();
        clear_model();
        add_line(first, t6[0], 0);
        for (int i = 1; i < 6; i++) add_line(gen_line(t6[i]), t6[i], i == 5);
        finish_stream();
        run_traffic(100, 100, 100, 0, 2000);
        total++; if (timeout || obs_data_q.size() != 6) begin bad++; $display("FAIL six_count got=%0d want=6", obs_data_q.size()); end
        if (obs_data_q.size() == 6) begin
            total++; if (obs_data_q[0] !== first) begin bad++; $display("FAIL six_first got=%h want=%h", obs_data_q[0], first); end
            for (int i = 0; i < 6; i++) begin
                total++;
                if (obs_data_q[i] !== exp_q[i] || obs_tag_q[i] !== t6[i] || obs_last_q[i] !== (i == 5)) begin
                    bad++;
                    $display("FAIL six_line%0d got=%h/%h/%b want=%h/%h/%b", i, obs_data_q[i], obs_tag_q[i],
                             obs_last_q[i], exp_q[i], t6[i], (i == 5));
                end
            end
        end
    endtask

    task automatic test_padding();
        logic [255:0] a, b;
        a = {8'hAB, 248'd0};
        b = {8'hCD, 248'd0};
        do_reset();
        clear_model();
        add_line(a, 16'h4000, 1);
        add_line(b, 16'h4000, 1);
        finish_stream();
        run_traffic(100, 100, 100, 0, 2000);
        total++; if (timeout || obs_data_q.size() != 2) begin bad++; $display("FAIL pad_count got=%0d want=2", obs_data_q.size()); end
        if (obs_data_q.size() == 2) begin
            total++; if (obs_data_q[0] !== a) begin bad++; $display("FAIL pad_line0 got=%h want=%h", obs_data_q[0], a); end
            total++; if (obs_data_q[1] !== b) begin bad++; $display("FAIL pad_line1 got=%h want=%h", obs_data_q[1], b); end
        end
        total++; if (dut.frame_off_q !== 5'd0) begin bad++; $display("FAIL pad_frameoff got=%0d want=0", dut.frame_off_q); end
        total++; if (dut.count_q !== 7'd0) begin bad++; $display("FAIL pad_count_left got=%0d want=0", dut.count_q); end
    endtask

    task automatic test_backpressure();
        do_reset();
        clear_model();
        for (int i = 0; i < 8; i++) add_line(gen_line(16'hFFFF), 16'hFFFF, i == 7);
        finish_stream();
        run_traffic(100, 100, 100, 5, 2000);
        total++; if (timeout || obs_data_q.size() != 8) begin bad++; $display("FAIL bp_count got=%0d want=8", obs_data_q.size()); end
        total++; if (stall_changed) begin bad++; $display("FAIL bp_stable got=changed want=stable"); end
        total++; if (stall_tr) begin bad++; $display("FAIL bp_tagready got=1 want=0"); end
        total++; if (!stall_ir_low) begin bad++; $display("FAIL bp_inready_drop got=never want=low"); end
        if (obs_data_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (obs_data_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_line%0d got=%h want=%h", i, obs_data_q[i], exp_q[i]); end
            end
            for (int i = 0; i < 4; i++) begin
                total++;
                if (obs_cyc_q[i + 1] - obs_cyc_q[i] != 1) begin
                    bad++; $display("FAIL bp_rate%0d got=%0d want=1", i, obs_cyc_q[i + 1] - obs_cyc_q[i]);
                end
            end
        end
    endtask

    task automatic test_starvation();
        logic [255:0] beat;
        beat = {8{32'($urandom_range(32'hFFFFFFFF, 1) | 32'h0001_0001)}};
        do_reset();
        @(posedge clk); #1;
        tagValid = 1; tagIn = 16'hFFFF; tagLast = 0; outReady = 1;
        repeat (2) @(posedge clk);
        #1;
        inValid = 1; inData = beat;
        @(negedge clk);
        total++; if (tagReady !== 1'b0) begin bad++; $display("FAIL starve_idle got=%b want=0", tagReady); end
        @(posedge clk); #1;
        inValid = 0;
        @(negedge clk);
        total++; if (tagReady !== 1'b1 || outValid !== 1'b0) begin
            bad++; $display("FAIL starve_fire got=%b/%b want=1/0", tagReady, outValid);
        end
        @(posedge clk); #1;
        tagValid = 0;
        total++; if (outValid !== 1'b1 || dataOut !== beat || tagOut !== 16'hFFFF) begin
            bad++; $display("FAIL starve_out got=%b/%h want=1/%h", outValid, dataOut, beat);
        end
        @(posedge clk); #1;
        outReady = 0;
    endtask

    task automatic test_random();
        logic [255:0] l;
        int n;
        n = 4000;
        do_reset();
        clear_model();
        for (int i = 0; i < n; i++) begin
            l = gen_line(16'($urandom));
            add_line(l, tag_of(l), (i == n - 1) || ($urandom_range(7) == 0));
        end
        finish_stream();
        run_traffic(70, 70, 70, 0, 50000);
        total++; if (timeout || obs_data_q.size() != n) begin bad++; $display("FAIL rand_count got=%0d want=%0d", obs_data_q.size(), n); end
        total++; if (count_over) begin bad++; $display("FAIL rand_count_bound got=over want=<=64"); end
        for (int i = 0; i < obs_data_q.size() && i < n; i++) begin
            total++;
            if (obs_data_q[i] !== exp_q[i] || obs_tag_q[i] !== tags_q[i] || obs_last_q[i] !== tlast_q[i]) begin
                bad++;
                $display("FAIL rand_line%0d got=%h/%h want=%h/%h", i, obs_data_q[i], obs_tag_q[i], exp_q[i], tags_q[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1; inValid = 0; inData = '0; tagValid = 0; tagIn = '0; tagLast = 0; outReady = 0;
        test_reset();
        test_six_lines();
        test_padding();
        test_backpressure();
        test_starvation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
